// File: rtl/cbus_arbiter.sv
// cbus_arbiter: shares one cache bus between NUM_REQ cache-side masters.
// One winner is latched per transaction. The winner's request is forwarded to
// memory and the memory response is returned to it until ready && last.
// Build option: define CBUS_ARB_RR_EN for round-robin arbitration.
// When it is not defined, fixed priority is used and the lowest index wins.

typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
} cbus_req_t;

typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
} cbus_resp_t;

module cbus_arbiter #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  cbus_req_t  [NUM_REQ-1:0]       ireqs,
    output cbus_resp_t [NUM_REQ-1:0]       oresps,
    output cbus_req_t                      oreq,
    input  cbus_resp_t                     iresp,
    output logic [$clog2(NUM_REQ)-1:0]     owner,
    output logic                           busy
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] owner_next;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] rr_next;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] idx;
    logic             any_valid;

`ifdef CBUS_ARB_RR_EN
    // Winner selection: scan upward from rr_ptr with wrap-around and take the first valid request.
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        idx       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = IDX_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (!any_valid && ireqs[idx].valid) begin
                any_valid = 1'b1;
                winner    = idx;
            end
        end
    end
`else
    logic unused_rr;
    // rr_ptr is still tracked in this build but plays no part in the choice.
    assign unused_rr = ^rr_ptr;

    // Winner selection: the lowest valid index wins, so DCache has priority.
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        idx       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = IDX_W'(k);
            if (!any_valid && ireqs[idx].valid) begin
                any_valid = 1'b1;
                winner    = idx;
            end
        end
    end
`endif

    // State, owner and round-robin pointer registers, cleared asynchronously.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_next;
            owner  <= owner_next;
            rr_ptr <= rr_next;
        end
    end

    // Next-state logic plus the bus steering.
    // In IDLE nothing is driven, so there is no combinational path from ireqs to oreq.
    always_comb begin
        state_next = state;
        owner_next = owner;
        rr_next    = rr_ptr;
        oreq       = '0;
        oresps     = '0;
        unique case (state)
            IDLE: begin
                if (any_valid) begin
                    state_next = BUSY;
                    owner_next = winner;
                end
            end
            BUSY: begin
                oreq          = ireqs[owner];
                oresps[owner] = iresp;
                if (iresp.ready && iresp.last) begin
                    state_next = IDLE;
                    rr_next    = (32'(owner) == NUM_REQ - 1) ? '0 : owner + 1'b1;
                end
            end
        endcase
    end

    assign busy = (state == BUSY);

endmodule
